// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared FSM encodings, forwarding-select constants and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

   typedef enum logic {
      HALT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // MEM holds the younger result, so it wins over WB; r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] mem_rd, input logic mem_we,
                                          input logic [4:0] wb_rd,  input logic wb_we);
      if (mem_we && mem_rd != 5'd0 && mem_rd == src)
         return FWD_MEM;
      else if (wb_we && wb_rd != 5'd0 && wb_rd == src)
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational load-use detect, redirect flush and EX forwarding selects.
// Stall/flush/enable outputs are qualified by ce; forwarding selects are not.
module hazard_fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic       ce,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       ex_mem_to_reg,
   input  logic [4:0] ex_rd,
   input  logic       ex_write_reg,
   input  logic [4:0] mem_rd,
   input  logic [4:0] wb_rd,
   input  logic       mem_write_reg,
   input  logic       wb_write_reg,
   input  logic       mem_redirect,
   output logic       luse,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_bubble,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       flush_ex_mem,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   assign luse = ex_mem_to_reg & ex_write_reg & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

   // A redirect discards the stalled ID instruction anyway, so it overrides the stall.
   always_comb begin
      pc_en        = ce;
      if_id_en     = ce;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      if (ce) begin
         if (mem_redirect) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
         end else if (luse) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   assign fwd_a = fwd_sel(ex_rs, mem_rd, mem_write_reg, wb_rd, wb_write_reg);
   assign fwd_b = fwd_sel(ex_rt, mem_rd, mem_write_reg, wb_rd, wb_write_reg);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: run/step/breakpoint cycle enable, hazard control and perf counters.
// ce and all hazard outputs are combinational from the current state and inputs.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  if_pc,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mem_to_reg,
   input  logic [4:0]       ex_rd,
   input  logic             ex_write_reg,
   input  logic [4:0]       mem_rd,
   input  logic [4:0]       wb_rd,
   input  logic             mem_write_reg,
   input  logic             wb_write_reg,
   input  logic             mem_redirect,
   output logic             ce,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_bubble,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t state, state_nxt;
   logic   run_q, step_q, bp_skip, bp_skip_nxt;
   logic   run_rise, step_rise, bp_hit, luse;

   assign run_rise  = run & ~run_q;
   assign step_rise = step & ~step_q;
   assign halted    = (state == HALT);

   // bp_skip lets the instruction parked on the breakpoint execute once after resuming.
   always_comb begin
      state_nxt   = state;
      bp_skip_nxt = bp_skip;
      ce          = 1'b0;
      bp_hit      = 1'b0;
      case (state)
         HALT: begin
            ce = step_rise;
            if (run_rise) begin
               state_nxt   = RUN;
               bp_skip_nxt = 1'b1;
            end
         end
         RUN: begin
            bp_hit = bp_en & (if_pc == bp_addr) & ~bp_skip;
            if (!run || bp_hit) begin
               state_nxt = HALT;
            end else begin
               ce          = 1'b1;
               bp_skip_nxt = 1'b0;
            end
         end
         default: state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HALT;
         run_q     <= 1'b0;
         step_q    <= 1'b0;
         bp_skip   <= 1'b0;
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         run_q     <= run;
         step_q    <= step;
         bp_skip   <= bp_skip_nxt;
         cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, ce};
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, ce & luse & ~mem_redirect};
         flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, ce & mem_redirect};
      end
   end

   hazard_fwd_unit u_hazard_fwd (
      .ce            (ce),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_rd         (ex_rd),
      .ex_write_reg  (ex_write_reg),
      .mem_rd        (mem_rd),
      .wb_rd         (wb_rd),
      .mem_write_reg (mem_write_reg),
      .wb_write_reg  (wb_write_reg),
      .mem_redirect  (mem_redirect),
      .luse          (luse),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .id_ex_bubble  (id_ex_bubble),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .flush_ex_mem  (flush_ex_mem),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table in RUN and HALT plus debug-mode and counter sequences.
module tb_pipe_hazard_ctrl;

   localparam int PC_W  = 9;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             run, step, bp_en;
   logic [PC_W-1:0]  bp_addr, if_pc;
   logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic             id_uses_rt, ex_mem_to_reg, ex_write_reg;
   logic             mem_write_reg, wb_write_reg, mem_redirect;
   logic             ce, pc_en, if_id_en, id_ex_bubble;
   logic             flush_if_id, flush_id_ex, flush_ex_mem, halted;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
      .if_pc(if_pc), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
      .ex_write_reg(ex_write_reg), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .mem_write_reg(mem_write_reg), .wb_write_reg(wb_write_reg),
      .mem_redirect(mem_redirect), .ce(ce), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .flush_ex_mem(flush_ex_mem), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic       mtr, ewr;
      logic [4:0] ex_rd, id_rs, id_rt;
      logic       uses_rt, redir;
      logic [4:0] ex_rs, ex_rt, mem_rd, wb_rd;
      logic       mwr, wwr;
      logic       pc_en, if_id_en, bubble, flush;
      logic [1:0] fa, fb;
   } vec_t;

   vec_t tbl[15];
   vec_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      ex_mem_to_reg = v.mtr;   ex_write_reg = v.ewr;  ex_rd = v.ex_rd;
      id_rs = v.id_rs;         id_rt = v.id_rt;       id_uses_rt = v.uses_rt;
      mem_redirect = v.redir;  ex_rs = v.ex_rs;       ex_rt = v.ex_rt;
      mem_rd = v.mem_rd;       wb_rd = v.wb_rd;
      mem_write_reg = v.mwr;   wb_write_reg = v.wwr;
   endtask

   task automatic clear_inputs();
      vec_t z;
      z = '{0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00};
      drive(z);
      run = 0; step = 0; bp_en = 0; bp_addr = '0; if_pc = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      clear_inputs();
      @(negedge clk);
      rst = 0;
   endtask

   // Apply every table row for one cycle; with ce_on=0 the enables must all read 0.
   task automatic run_table(input logic ce_on, input string tag);
      vec_t e, got;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         e = tbl[i];
         e.pc_en    = tbl[i].pc_en & ce_on;
         e.if_id_en = tbl[i].if_id_en & ce_on;
         e.bubble   = tbl[i].bubble & ce_on;
         e.flush    = tbl[i].flush & ce_on;
         sb.push_back(e);
         #1;
         got = sb.pop_front();
         chk($sformatf("%s[%0d].pc_en", tag, i), int'(pc_en), int'(got.pc_en));
         chk($sformatf("%s[%0d].if_id_en", tag, i), int'(if_id_en), int'(got.if_id_en));
         chk($sformatf("%s[%0d].bubble", tag, i), int'(id_ex_bubble), int'(got.bubble));
         chk($sformatf("%s[%0d].flush_if_id", tag, i), int'(flush_if_id), int'(got.flush));
         chk($sformatf("%s[%0d].flush_id_ex", tag, i), int'(flush_id_ex), int'(got.flush));
         chk($sformatf("%s[%0d].flush_ex_mem", tag, i), int'(flush_ex_mem), int'(got.flush));
         chk($sformatf("%s[%0d].fwd_a", tag, i), int'(fwd_a), int'(got.fa));
         chk($sformatf("%s[%0d].fwd_b", tag, i), int'(fwd_b), int'(got.fb));
         chk($sformatf("%s[%0d].ce", tag, i), int'(ce), int'(ce_on));
      end
   endtask

   initial begin
      //        mtr ewr exrd idrs idrt urt rdr  exrs exrt memrd wbrd mwr wwr  pc  ifid bub fl  fa     fb
      tbl[0]  = '{0,0, 0, 0, 0, 0,0,  0, 0, 0, 0, 0,0,  1,1,0,0, 2'b00,2'b00};
      tbl[1]  = '{1,1, 8, 8, 0, 0,0,  1, 2, 0, 0, 0,0,  0,0,1,0, 2'b00,2'b00};
      tbl[2]  = '{1,1, 0, 0, 0, 0,0,  0, 0, 0, 0, 0,0,  1,1,0,0, 2'b00,2'b00};
      tbl[3]  = '{1,1, 8, 1, 8, 0,0,  0, 0, 0, 0, 0,0,  1,1,0,0, 2'b00,2'b00};
      tbl[4]  = '{1,1, 8, 1, 8, 1,0,  0, 0, 0, 0, 0,0,  0,0,1,0, 2'b00,2'b00};
      tbl[5]  = '{1,1, 8, 8, 0, 0,1,  0, 0, 0, 0, 0,0,  1,1,0,1, 2'b00,2'b00};
      tbl[6]  = '{0,0, 0, 0, 0, 0,1,  0, 0, 0, 0, 0,0,  1,1,0,1, 2'b00,2'b00};
      tbl[7]  = '{1,0, 8, 8, 0, 0,0,  0, 0, 0, 0, 0,0,  1,1,0,0, 2'b00,2'b00};
      tbl[8]  = '{0,0, 0, 0, 0, 0,0,  3, 0, 3, 3, 1,1,  1,1,0,0, 2'b10,2'b00};
      tbl[9]  = '{0,0, 0, 0, 0, 0,0,  3, 0, 3, 3, 0,1,  1,1,0,0, 2'b01,2'b00};
      tbl[10] = '{0,0, 0, 0, 0, 0,0,  0, 0, 0, 0, 1,1,  1,1,0,0, 2'b00,2'b00};
      tbl[11] = '{0,0, 0, 0, 0, 0,0,  7, 5, 5, 7, 1,1,  1,1,0,0, 2'b01,2'b10};
      tbl[12] = '{0,0, 0, 0, 0, 0,0,  5, 5, 5, 5, 0,1,  1,1,0,0, 2'b01,2'b01};
      tbl[13] = '{0,0, 0, 0, 0, 0,0,  5, 5, 5, 5, 1,0,  1,1,0,0, 2'b10,2'b10};
      tbl[14] = '{1,1,31, 2,31, 1,0,  9, 4, 9, 4, 1,1,  0,0,1,0, 2'b10,2'b01};

      // Reset state
      rst = 1;
      clear_inputs();
      #1;
      chk("rst.halted", int'(halted), 1);
      chk("rst.ce", int'(ce), 0);
      chk("rst.pc_en", int'(pc_en), 0);
      chk("rst.bubble", int'(id_ex_bubble), 0);
      chk("rst.flush", int'(flush_if_id | flush_id_ex | flush_ex_mem), 0);
      chk("rst.cycle_cnt", int'(cycle_cnt), 0);
      chk("rst.stall_cnt", int'(stall_cnt), 0);
      chk("rst.flush_cnt", int'(flush_cnt), 0);
      @(negedge clk);
      rst = 0;

      // Single-step: one ce pulse per rising edge of step
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); step = 1; #1;
         chk("step.rise_ce", int'(ce), 1);
         chk("step.halted", int'(halted), 1);
         @(negedge clk); #1;
         chk("step.hold_ce", int'(ce), 0);
         step = 0;
         @(negedge clk); #1;
         chk("step.low_ce", int'(ce), 0);
         chk("step.low_halted", int'(halted), 1);
      end
      chk("step.cycle_cnt", int'(cycle_cnt), 3);

      // Breakpoint at PC 5
      do_reset();
      bp_en = 1; bp_addr = 9'd5; if_pc = 9'd0;
      @(negedge clk); run = 1; #1;
      chk("bp.entry_ce", int'(ce), 0);
      for (int p = 0; p < 5; p++) begin
         @(negedge clk); if_pc = 9'(p); #1;
         chk($sformatf("bp.pc%0d_ce", p), int'(ce), 1);
      end
      @(negedge clk); if_pc = 9'd5; #1;
      chk("bp.hit_ce", int'(ce), 0);
      chk("bp.hit_halted", int'(halted), 0);
      @(negedge clk); #1;
      chk("bp.halted", int'(halted), 1);
      chk("bp.halt_ce", int'(ce), 0);
      run = 0;
      @(negedge clk); run = 1; #1;
      chk("bp.resume_ce", int'(ce), 0);
      @(negedge clk); #1;
      chk("bp.skip_ce", int'(ce), 1);
      @(negedge clk); if_pc = 9'd6; #1;
      chk("bp.pc6_ce", int'(ce), 1);
      @(negedge clk); if_pc = 9'd5; #1;
      chk("bp.rehit_ce", int'(ce), 0);
      chk("bp.cycle_cnt", int'(cycle_cnt), 7);
      @(negedge clk); #1;
      chk("bp.rehit_halted", int'(halted), 1);
      run = 0; bp_en = 0;

      // Simultaneous run and step rising edges in HALT
      @(negedge clk); run = 1; step = 1; #1;
      chk("both.ce", int'(ce), 1);
      chk("both.halted", int'(halted), 1);
      @(negedge clk); step = 0; #1;
      chk("both.run_halted", int'(halted), 0);
      chk("both.run_ce", int'(ce), 1);
      @(negedge clk); run = 0; #1;
      chk("both.drop_ce", int'(ce), 0);
      @(negedge clk); #1;
      chk("both.back_halted", int'(halted), 1);

      // Hazard/forwarding table in RUN, then again in HALT
      do_reset();
      @(negedge clk); run = 1;
      @(posedge clk);
      run_table(1'b1, "run");
      @(negedge clk);
      clear_inputs(); #1;
      chk("tbl.drop_ce", int'(ce), 0);
      chk("tbl.cycle_cnt", int'(cycle_cnt), 15);
      chk("tbl.stall_cnt", int'(stall_cnt), 3);
      chk("tbl.flush_cnt", int'(flush_cnt), 2);
      run_table(1'b0, "halt");
      @(negedge clk); #1;
      chk("halt.halted", int'(halted), 1);
      chk("halt.cycle_cnt", int'(cycle_cnt), 15);
      chk("halt.stall_cnt", int'(stall_cnt), 3);
      chk("halt.flush_cnt", int'(flush_cnt), 2);

      // Counter wrap, then asynchronous reset mid-run
      do_reset();
      @(negedge clk); run = 1;
      @(posedge clk);
      repeat (65538) @(posedge clk);
      @(negedge clk); #1;
      chk("wrap.cycle_cnt", int'(cycle_cnt), 2);
      chk("wrap.running", int'(halted), 0);
      #1 rst = 1; #1;
      chk("arst.halted", int'(halted), 1);
      chk("arst.ce", int'(ce), 0);
      chk("arst.cycle_cnt", int'(cycle_cnt), 0);
      chk("arst.stall_cnt", int'(stall_cnt), 0);
      chk("arst.flush_cnt", int'(flush_cnt), 0);
      run = 0;
      @(negedge clk); rst = 0;
      @(negedge clk); #1;
      chk("post.halted", int'(halted), 1);
      chk("post.cycle_cnt", int'(cycle_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
